mux2_rr_arbiter: RTL and testbench
==================================

Name: mux2_rr_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one 2:1 data multiplexer between two requesters (A, B) and drives a single downstream channel.
- Packet-granular: a grant is held until the granted requester's last beat is accepted, or until a beat-count limit forces release.
- Output is registered through a single-entry output stage, giving 1-cycle latency, with valid/ready handshakes on all channels.
- Sits between two producer blocks and one shared consumer.

Parameters:
- WIDTH, 8, data width of every channel.
- MAX_BEATS, 16, maximum beats per grant before forced release; must be ≥ 1.
- CNT_W, 5, beat counter width; must satisfy 2^CNT_W > MAX_BEATS.

Ports:
- clk  input  1  single system clock; all logic is on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- a_valid  input  1  requester A has a beat.
- a_data  input  WIDTH  requester A beat data.
- a_last  input  1  final beat of A's packet.
- a_ready  output  1  A beat accepted this cycle.
- b_valid  input  1  requester B has a beat.
- b_data  input  WIDTH  requester B beat data.
- b_last  input  1  final beat of B's packet.
- b_ready  output  1  B beat accepted this cycle.
- o_valid  output  1  output register holds a beat.
- o_data  output  WIDTH  registered output data.
- o_last  output  1  registered last flag; also set on a forced-release beat.
- o_ready  input  1  downstream accepts the beat.
- o_src  output  1  source of the held beat: 0 = A, 1 = B.
- overrun  output  1  one-cycle pulse when a grant is ended by MAX_BEATS.

Behaviour:
- Reset (asynchronous, rst_n = 0):
  - FSM goes to IDLE; prio = A; beat counter = 0.
  - o_valid = 0, o_data = 0, o_last = 0, o_src = 0, overrun = 0.
  - a_ready = b_ready = 0.
- Reset asserted mid-packet: the packet is dropped, with no partial flush. The first grant after release of reset follows prio = A.
- FSM states:
  - IDLE:
    - No grant.
    - Both valid: grant the requester named by prio.
    - Only one valid: grant it.
    - Transition to GNT_A or GNT_B on the next edge; no beat is taken in IDLE (1 arbitration bubble).
  - GNT_A / GNT_B:
    - sel of the internal mux follows the grant.
    - The granted ready is asserted when (!o_valid || o_ready); the non-granted ready is 0.
    - A beat is accepted when the granted valid and ready are both high.
- On an accepted beat:
  - The output register loads data, last, and src; o_valid is set.
  - The beat counter increments.
- End of grant: the accepted beat has last = 1, or the counter reaches MAX_BEATS.
  - FSM returns to IDLE next cycle.
  - prio is set to the other requester.
  - Counter clears.
- Forced release (counter reaches MAX_BEATS on a beat with last = 0):
  - o_last is set on that beat.
  - overrun pulses for exactly 1 cycle, coincident with the register load.
  - The remainder of that packet is arbitrated as a new packet later.
- Output register:
  - Holds when o_valid && !o_ready; o_data/o_last/o_src must not change while held.
  - Clears o_valid when o_ready is high and no new beat is loaded.
  - Simultaneous unload and load in the same cycle is allowed (full throughput).
- Requester constraints:
  - A requester may drop valid mid-packet. The grant is held (no timeout) until its last beat or MAX_BEATS.
  - The non-granted requester's valid is ignored and never starved: after any grant ends, prio favours it.
- Latency: beat accepted at edge N appears at o_* after edge N. Steady-state throughput is 1 beat/cycle, plus 1 idle cycle per packet.

Test Plan:
- Single-beat packets: A sends 0x11 (last = 1) with B idle and o_ready = 1 → a_ready high 1 cycle after a_valid; o_data = 0x11, o_src = 0, o_last = 1 one cycle later; FSM back to IDLE.
- Contention: A and B both valid from reset, each sending 3-beat packets (A: 0xA0–0xA2, B: 0xB0–0xB2) → output order A0, A1, A2, (bubble), B0, B1, B2; then B2 followed by a new A packet, proving alternation.
- Backpressure: during an A packet, o_ready = 0 for 4 cycles → o_data stays constant; a_ready = 0; no beat lost or duplicated; flow resumes at 1 beat/cycle.
- Forced release: MAX_BEATS = 4, A sends a 6-beat packet with B waiting → beat 4 carries o_last = 1 and overrun pulses once; B's packet is granted next; A's remaining 2 beats follow after B.
- Async reset mid-packet: rst_n = 0 for half a cycle during A's beat 2 → o_valid, a_ready, b_ready drop immediately; after release, simultaneous A/B valid grants A first.
- Bubble with valid gaps: granted B deasserts valid for 3 cycles mid-packet while A is valid → b_ready stays asserted; A is never granted until B's last beat is accepted.

Source files
------------

// File: rtl/mux2_rr_arbiter.sv
// Round-robin arbiter sharing one 2:1 mux between requesters A and B, with
// packet-granular grants, a beat-count cap and a single-entry output register.
module mux2_rr_arbiter #(
   parameter int WIDTH     = 8,
   parameter int MAX_BEATS = 16,
   parameter int CNT_W     = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             a_valid,
   input  logic [WIDTH-1:0] a_data,
   input  logic             a_last,
   output logic             a_ready,
   input  logic             b_valid,
   input  logic [WIDTH-1:0] b_data,
   input  logic             b_last,
   output logic             b_ready,
   output logic             o_valid,
   output logic [WIDTH-1:0] o_data,
   output logic             o_last,
   input  logic             o_ready,
   output logic             o_src,
   output logic             overrun,
   output logic [1:0]       o_dbg_state
);

   // Handshake: a beat moves on any channel only in a cycle where valid and
   // ready are both high; ready never depends on the same channel's valid.
   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_GNT_A = 2'd1,
      S_GNT_B = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] L_CNT_MAX = CNT_W'(MAX_BEATS);

   state_t           r_state;
   state_t           w_next;
   logic             r_prio;
   logic [CNT_W-1:0] r_cnt;
   logic             r_o_valid;
   logic [WIDTH-1:0] r_o_data;
   logic             r_o_last;
   logic             r_o_src;
   logic             r_overrun;

   logic             w_gnt;
   logic             w_sel;
   logic [WIDTH-1:0] w_mux_data;
   logic             w_mux_last;
   logic             w_gv;
   logic             w_out_free;
   logic             w_accept;
   logic [CNT_W-1:0] w_cnt_inc;
   logic             w_cap;
   logic             w_end;
   logic             w_force;

   assign w_gnt      = (r_state == S_GNT_A) || (r_state == S_GNT_B);
   assign w_sel      = (r_state == S_GNT_B);
   assign w_mux_data = w_sel ? b_data  : a_data;
   assign w_mux_last = w_sel ? b_last  : a_last;
   assign w_gv       = w_sel ? b_valid : a_valid;
   assign w_out_free = !r_o_valid || o_ready;

   assign a_ready    = (r_state == S_GNT_A) && w_out_free;
   assign b_ready    = (r_state == S_GNT_B) && w_out_free;
   assign w_accept   = w_gnt && w_gv && w_out_free;

   // The cap is judged on the count including the beat being accepted now.
   assign w_cnt_inc  = r_cnt + CNT_W'(1);
   assign w_cap      = (w_cnt_inc == L_CNT_MAX);
   assign w_end      = w_accept && (w_mux_last || w_cap);
   assign w_force    = w_accept && w_cap && !w_mux_last;

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (a_valid && b_valid) w_next = r_prio ? S_GNT_B : S_GNT_A;
            else if (a_valid)       w_next = S_GNT_A;
            else if (b_valid)       w_next = S_GNT_B;
         end
         S_GNT_A, S_GNT_B: begin
            if (w_end) w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_prio  <= 1'b0;
         r_cnt   <= '0;
      end else begin
         r_state <= w_next;
         if (w_end) begin
            r_prio <= !w_sel;
            r_cnt  <= '0;
         end else if (w_accept) begin
            r_cnt  <= w_cnt_inc;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_o_valid <= 1'b0;
         r_o_data  <= '0;
         r_o_last  <= 1'b0;
         r_o_src   <= 1'b0;
         r_overrun <= 1'b0;
      end else begin
         r_overrun <= w_force;
         if (w_accept) begin
            r_o_valid <= 1'b1;
            r_o_data  <= w_mux_data;
            r_o_last  <= w_mux_last || w_cap;
            r_o_src   <= w_sel;
         end else if (o_ready) begin
            r_o_valid <= 1'b0;
         end
      end
   end

   assign o_valid     = r_o_valid;
   assign o_data      = r_o_data;
   assign o_last      = r_o_last;
   assign o_src       = r_o_src;
   assign overrun     = r_overrun;
   assign o_dbg_state = r_state;

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// Directed and randomized bench for mux2_rr_arbiter against a beat-level
// reference model of grants, turns and the output register.
module tb_mux2_rr_arbiter;
   localparam int W    = 8;
   localparam int MAXB = 4;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         a_valid, a_last, b_valid, b_last, o_ready;
   logic [W-1:0] a_data, b_data;
   logic         a_ready, b_ready, o_valid, o_last, o_src, overrun;
   logic [W-1:0] o_data;
   logic [1:0]   dbg_state;

   mux2_rr_arbiter #(.WIDTH(W), .MAX_BEATS(MAXB), .CNT_W(3)) dut (
      .clk(clk), .rst_n(rst_n),
      .a_valid(a_valid), .a_data(a_data), .a_last(a_last), .a_ready(a_ready),
      .b_valid(b_valid), .b_data(b_data), .b_last(b_last), .b_ready(b_ready),
      .o_valid(o_valid), .o_data(o_data), .o_last(o_last), .o_ready(o_ready),
      .o_src(o_src), .overrun(overrun), .o_dbg_state(dbg_state)
   );

   always #5 clk = ~clk;

   typedef struct packed { logic [W-1:0] d; logic l; } beat_t;
   beat_t          qa[$], qb[$];
   logic [W+1:0]   exp_q[$], got_q[$];   // {src, last, data}
   int             n_checks = 0, n_err = 0;

   // reference model: owner 0 = none, 1 = A, 2 = B; turn names who wins a tie
   int             m_own, m_turn, m_beats;
   bit             m_v, m_l, m_s, m_ovr;
   logic [W-1:0]   m_d;
   int             gap_pct = 0, rdy_pct = 100, ovr_seen = 0, total = 0;
   bit             a_block = 0, b_block = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_own = 0; m_turn = 1; m_beats = 0;
      m_v = 0; m_l = 0; m_s = 0; m_ovr = 0; m_d = '0;
   endtask

   task automatic push_pkt(input int src, input int n, input logic [W-1:0] base, input bit rnd);
      beat_t bt;
      for (int i = 0; i < n; i++) begin
         bt.d = rnd ? W'($urandom) : base + W'(i);
         bt.l = (i == n - 1);
         if (src == 1) qa.push_back(bt); else qb.push_back(bt);
         total++;
      end
   endtask

   function automatic logic [W+1:0] mk(input bit src, input bit last, input logic [W-1:0] d);
      return {src, last, d};
   endfunction

   task automatic cycle();
      bit free, ea, eb, acc;
      int old_own;
      beat_t bt;
      @(negedge clk);
      a_valid = 0; a_data = '0; a_last = 0;
      b_valid = 0; b_data = '0; b_last = 0;
      if (qa.size() > 0) begin
         a_data = qa[0].d; a_last = qa[0].l;
         a_valid = !a_block && ($urandom_range(99) >= gap_pct);
      end
      if (qb.size() > 0) begin
         b_data = qb[0].d; b_last = qb[0].l;
         b_valid = !b_block && ($urandom_range(99) >= gap_pct);
      end
      o_ready = ($urandom_range(99) < rdy_pct);
      #1;
      free = !m_v || o_ready;
      ea = (m_own == 1) && free;
      eb = (m_own == 2) && free;
      check("a_ready", 32'(a_ready), 32'(ea));
      check("b_ready", 32'(b_ready), 32'(eb));
      if (o_valid && o_ready) got_q.push_back({o_src, o_last, o_data});
      acc = (ea && a_valid) || (eb && b_valid);
      old_own = m_own;
      m_ovr = 0;
      if (acc) begin
         if (old_own == 1) bt = qa[0]; else bt = qb[0];
         m_beats++;
         m_d = bt.d; m_s = (old_own == 2); m_v = 1;
         m_l = bt.l || (m_beats == MAXB);
         m_ovr = !bt.l && (m_beats == MAXB);
         if (m_l) begin
            m_turn = (old_own == 1) ? 2 : 1;
            m_own = 0; m_beats = 0;
         end
      end else if (o_ready) begin
         m_v = 0;
      end
      if (old_own == 0) begin
         if (a_valid && b_valid) m_own = m_turn;
         else if (a_valid)       m_own = 1;
         else if (b_valid)       m_own = 2;
      end
      @(posedge clk); #1;
      if (acc) begin
         if (old_own == 1) void'(qa.pop_front()); else void'(qb.pop_front());
      end
      check("o_valid", 32'(o_valid), 32'(m_v));
      check("o_data",  32'(o_data),  32'(m_d));
      check("o_last",  32'(o_last),  32'(m_l));
      check("o_src",   32'(o_src),   32'(m_s));
      check("overrun", 32'(overrun), 32'(m_ovr));
      ovr_seen += int'(overrun);
   endtask

   task automatic drain(input int max, input string tag);
      int k = 0;
      while ((qa.size() > 0 || qb.size() > 0 || m_own != 0 || m_v) && k < max) begin
         cycle();
         k++;
      end
      check(tag, 32'(k < max), 32'd1);
   endtask

   task automatic do_reset();
      a_valid = 0; b_valid = 0; o_ready = 0;
      rst_n = 0;
      #1;
      check("rst_o_valid", 32'(o_valid), 32'd0);
      check("rst_a_ready", 32'(a_ready), 32'd0);
      check("rst_b_ready", 32'(b_ready), 32'd0);
      check("rst_overrun", 32'(overrun), 32'd0);
      check("rst_o_data",  32'(o_data),  32'd0);
      check("rst_o_src",   32'(o_src),   32'd0);
      @(negedge clk);
      rst_n = 1;
      model_reset();
      qa.delete(); qb.delete(); got_q.delete(); exp_q.delete();
   endtask

   task automatic cmp_stream(input string tag);
      check({tag, "_len"}, 32'(got_q.size()), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
         check({tag, "_beat"}, 32'(got_q[i]), 32'(exp_q[i]));
   endtask

   initial begin
      rst_n = 1; a_valid = 0; b_valid = 0; o_ready = 0;
      a_data = '0; b_data = '0; a_last = 0; b_last = 0;
      #2;
      do_reset();

      // single-beat packet from A
      push_pkt(1, 1, 8'h11, 0);
      cycle();
      cycle();
      check("single_valid", 32'(o_valid), 32'd1);
      check("single_data",  32'(o_data),  32'h11);
      check("single_src",   32'(o_src),   32'd0);
      check("single_last",  32'(o_last),  32'd1);
      drain(20, "single_timeout");

      // contention and alternation
      do_reset();
      push_pkt(1, 3, 8'hA0, 0); push_pkt(2, 3, 8'hB0, 0); push_pkt(1, 2, 8'hC0, 0);
      exp_q = '{mk(0,0,8'hA0), mk(0,0,8'hA1), mk(0,1,8'hA2),
                mk(1,0,8'hB0), mk(1,0,8'hB1), mk(1,1,8'hB2),
                mk(0,0,8'hC0), mk(0,1,8'hC1)};
      drain(50, "contend_timeout");
      cmp_stream("contend");

      // backpressure for 4 cycles mid-packet
      do_reset();
      push_pkt(1, 3, 8'hD0, 0);
      cycle(); cycle();
      rdy_pct = 0;
      repeat (4) cycle();
      rdy_pct = 100;
      exp_q = '{mk(0,0,8'hD0), mk(0,0,8'hD1), mk(0,1,8'hD2)};
      drain(30, "bp_timeout");
      cmp_stream("bp");

      // forced release at MAX_BEATS
      do_reset();
      ovr_seen = 0;
      push_pkt(1, 6, 8'hE0, 0); push_pkt(2, 2, 8'hF0, 0);
      exp_q = '{mk(0,0,8'hE0), mk(0,0,8'hE1), mk(0,0,8'hE2), mk(0,1,8'hE3),
                mk(1,0,8'hF0), mk(1,1,8'hF1), mk(0,0,8'hE4), mk(0,1,8'hE5)};
      drain(50, "force_timeout");
      cmp_stream("force");
      check("overrun_count", 32'(ovr_seen), 32'd1);

      // reset in the middle of A's packet
      do_reset();
      push_pkt(1, 4, 8'h30, 0); push_pkt(2, 2, 8'h40, 0);
      cycle(); cycle();
      do_reset();
      push_pkt(1, 1, 8'h50, 0); push_pkt(2, 1, 8'h60, 0);
      exp_q = '{mk(0,1,8'h50), mk(1,1,8'h60)};
      drain(30, "rstmid_timeout");
      cmp_stream("rstmid");

      // granted B pauses while A waits
      do_reset();
      push_pkt(2, 3, 8'h70, 0);
      cycle(); cycle();
      push_pkt(1, 2, 8'h80, 0);
      b_block = 1;
      repeat (3) cycle();
      b_block = 0;
      exp_q = '{mk(1,0,8'h70), mk(1,0,8'h71), mk(1,1,8'h72), mk(0,0,8'h80), mk(0,1,8'h81)};
      drain(30, "gap_timeout");
      cmp_stream("gap");

      // randomized traffic
      do_reset();
      total = 0;
      gap_pct = 30; rdy_pct = 70;
      for (int i = 0; i < 20; i++) begin
         push_pkt(1, $urandom_range(6, 1), '0, 1);
         push_pkt(2, $urandom_range(6, 1), '0, 1);
      end
      drain(3000, "rand_timeout");
      check("rand_count", 32'(got_q.size()), 32'(total));

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end
endmodule
